// File: rtl/sdram_burst_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sdram_burst_arbiter_if
// Purpose  : Groups the signals of the SDRAM/PSRAM burst arbiter.
//            Requester side: the camera store path (write bursts) and the
//            LCD load path (read bursts).
//            Memory side: the command/data port of the memory controller.
// Modports : slave  - used by the arbiter itself
//            master - used by whatever drives the requesters and the memory
//                     controller around the arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface sdram_burst_arbiter_if #(
  parameter int ADDR_WIDTH = 21
);
  // controller status
  logic                  init_done;
  // store path (write bursts)
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data_in;
  logic                  wr_data_rd;
  logic                  wr_done;
  // load path (read bursts)
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [31:0]           rd_data_out;
  logic                  rd_data_out_valid;
  logic                  rd_done;
  // memory controller command port
  logic                  cmd;
  logic                  cmd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wr_data;
  logic [31:0]           rd_data;
  logic                  rd_data_valid;
  logic                  error;

  modport slave (
    input  init_done, wr_req, wr_addr, wr_data_in, rd_req, rd_addr,
           rd_data, rd_data_valid,
    output wr_data_rd, wr_done, rd_data_out, rd_data_out_valid, rd_done,
           cmd, cmd_en, addr, wr_data, error
  );

  modport master (
    output init_done, wr_req, wr_addr, wr_data_in, rd_req, rd_addr,
           rd_data, rd_data_valid,
    input  wr_data_rd, wr_done, rd_data_out, rd_data_out_valid, rd_done,
           cmd, cmd_en, addr, wr_data, error
  );
endinterface
`default_nettype wire

// File: rtl/sdram_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_burst_arbiter
// Purpose  : Shares one memory-controller command port between a burst-write
//            requester and a burst-read requester. One burst at a time,
//            round-robin on ties, one-cycle cmd_en, write data streamed
//            straight from a FWFT source, read data forwarded with one
//            register stage, sticky error on read timeout.
// Ports    : clk   - frame-buffer clock
//            rst_n - asynchronous active-low reset
//            bus   - sdram_burst_arbiter_if.slave (requesters + controller)
// Config   : SDRAM_ARB_READ_PRIORITY_EN - when defined, a read always wins a
//            tie; otherwise ties alternate (first tie goes to the read).
// Params   : ADDR_WIDTH, BURST_WORDS (2..64), WR_RECOVERY, RD_TIMEOUT (>=2)
// Revision : 1.0 - initial release
// ============================================================================
module sdram_burst_arbiter #(
  parameter int ADDR_WIDTH  = 21,
  parameter int BURST_WORDS = 8,
  parameter int WR_RECOVERY = 4,
  parameter int RD_TIMEOUT  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sdram_burst_arbiter_if.slave bus
);

  localparam int BEAT_W = $clog2(BURST_WORDS);
  localparam int REC_W  = $clog2(WR_RECOVERY + 2);
  localparam int TMO_W  = $clog2(RD_TIMEOUT + 1);

  localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(BURST_WORDS - 1);
  localparam logic [REC_W-1:0]  c_REC_LAST  = REC_W'(WR_RECOVERY - 1);
  localparam logic [TMO_W-1:0]  c_TMO_LAST  = TMO_W'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    WAIT_INIT  = 3'd0,
    IDLE       = 3'd1,
    WR_BURST   = 3'd2,
    WR_RECOVER = 3'd3,
    RD_CMD     = 3'd4,
    RD_WAIT    = 3'd5,
    RD_DATA    = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [REC_W-1:0]      rec_q, rec_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_done_q, rd_done_d;
  logic                  error_q, error_d;
  logic                  pick_rd;
  logic                  cmd_en;
  logic                  wr_data_rd;
  logic                  wr_done;

`ifdef SDRAM_ARB_READ_PRIORITY_EN
  // Display must never starve: a pending read beats a pending write.
  assign pick_rd = bus.rd_req;
`else
  // 1 = the most recent grant went to the read side.
  logic last_rd_q, last_rd_d;
  assign pick_rd = bus.rd_req & ~(bus.wr_req & last_rd_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_INIT;
      beat_q     <= '0;
      rec_q      <= '0;
      tmo_q      <= '0;
      cmd_q      <= 1'b0;
      addr_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_done_q  <= 1'b0;
      error_q    <= 1'b0;
`ifdef SDRAM_ARB_READ_PRIORITY_EN
`else
      last_rd_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      rec_q      <= rec_d;
      tmo_q      <= tmo_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_done_q  <= rd_done_d;
      error_q    <= error_d;
`ifdef SDRAM_ARB_READ_PRIORITY_EN
`else
      last_rd_q  <= last_rd_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    rec_d      = rec_q;
    tmo_d      = tmo_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_done_d  = 1'b0;
    error_d    = error_q;
    cmd_en     = 1'b0;
    wr_data_rd = 1'b0;
    wr_done    = 1'b0;
`ifdef SDRAM_ARB_READ_PRIORITY_EN
`else
    last_rd_d  = last_rd_q;
`endif

    case (state_q)
      WAIT_INIT: begin
        if (bus.init_done) state_d = IDLE;
      end

      IDLE: begin
        // The winner's address is captured here so addr/cmd are already
        // stable in the cmd_en cycle and keep holding afterwards.
        if (bus.wr_req || bus.rd_req) begin
          beat_d = '0;
`ifdef SDRAM_ARB_READ_PRIORITY_EN
`else
          last_rd_d = pick_rd;
`endif
          if (pick_rd) begin
            cmd_d   = 1'b0;
            addr_d  = bus.rd_addr;
            state_d = RD_CMD;
          end else begin
            cmd_d   = 1'b1;
            addr_d  = bus.wr_addr;
            state_d = WR_BURST;
          end
        end
      end

      WR_BURST: begin
        // The strobe cycle already consumes the first FWFT word.
        wr_data_rd = 1'b1;
        cmd_en     = (beat_q == '0);
        beat_d     = beat_q + 1'b1;
        if (beat_q == c_LAST_BEAT) begin
          wr_done = 1'b1;
          rec_d   = '0;
          state_d = (WR_RECOVERY == 0) ? IDLE : WR_RECOVER;
        end
      end

      WR_RECOVER: begin
        rec_d = rec_q + 1'b1;
        if (rec_q == c_REC_LAST) state_d = IDLE;
      end

      RD_CMD: begin
        cmd_en  = 1'b1;
        tmo_d   = TMO_W'(1);   // counts cycles elapsed since cmd_en
        state_d = RD_WAIT;
      end

      RD_WAIT, RD_DATA: begin
        if (bus.rd_data_valid) begin
          rd_data_d  = bus.rd_data;
          rd_valid_d = 1'b1;
          beat_d     = beat_q + 1'b1;
          state_d    = RD_DATA;
          if (beat_q == c_LAST_BEAT) begin
            rd_done_d = 1'b1;   // lines up with the last forwarded beat
            state_d   = IDLE;
          end
        end else if (state_q == RD_WAIT) begin
          // Only the wait for the first beat is timed.
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == c_TMO_LAST) begin
            error_d   = 1'b1;
            rd_done_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      default: state_d = WAIT_INIT;
    endcase
  end

  assign bus.cmd_en            = cmd_en;
  assign bus.cmd               = cmd_q;
  assign bus.addr              = addr_q;
  assign bus.wr_data           = bus.wr_data_in;
  assign bus.wr_data_rd        = wr_data_rd;
  assign bus.wr_done           = wr_done;
  assign bus.rd_data_out       = rd_data_q;
  assign bus.rd_data_out_valid = rd_valid_q;
  assign bus.rd_done           = rd_done_q;
  assign bus.error             = error_q;

endmodule
`default_nettype wire

// File: doc/sdram_burst_arbiter.md
# sdram_burst_arbiter

Shares the single SDRAM/PSRAM controller command port between the camera store path (burst writes) and the LCD load path (burst reads) inside the video pipeline. Accepts one burst request at a time from each side, arbitrates round-robin, issues a one-cycle `cmd_en`, streams write data or forwards read data, and reports completion. Runs in the frame-buffer clock domain, between `VideoController`'s store/load sequencers and the memory controller.

## Interface
- `ADDR_WIDTH`, 21, memory word address width
- `BURST_WORDS`, 8, 32-bit words per burst (2..64)
- `WR_RECOVERY`, 4, idle cycles after last write word before next command
- `RD_TIMEOUT`, 64, max cycles from read `cmd_en` to first `rd_data_valid`

- `clk` in 1 frame-buffer clock
- `rst_n` in 1 asynchronous active-low reset
- `init_done` in 1 memory controller calibrated
- `wr_req` in 1 store path requests a write burst; held until `wr_done`
- `wr_addr` in ADDR_WIDTH write burst base address
- `wr_data_in` in 32 write word, first-word-fall-through source
- `wr_data_rd` out 1 write word consumed this cycle
- `wr_done` out 1 one-cycle pulse, write burst finished
- `rd_req` in 1 load path requests a read burst; held until `rd_done`
- `rd_addr` in ADDR_WIDTH read burst base address
- `rd_data_out` out 32 forwarded read word
- `rd_data_out_valid` out 1 `rd_data_out` valid
- `rd_done` out 1 one-cycle pulse, read burst finished (or aborted)
- `cmd` out 1 1 = write, 0 = read
- `cmd_en` out 1 one-cycle command strobe
- `addr` out ADDR_WIDTH command address
- `wr_data` out 32 write data to controller
- `rd_data` in 32 read data from controller
- `rd_data_valid` in 1 read data strobe
- `error` out 1 sticky read-timeout flag

## Operation
- States: WAIT_INIT, IDLE, WR_BURST, WR_RECOVER, RD_CMD, RD_WAIT, RD_DATA.
- WAIT_INIT -> IDLE when `init_done`=1; requests ignored before.
- IDLE: if any request, pick winner, latch its address, go WR_BURST (write) or RD_CMD (read).
- Arbitration: single requester wins; both requesting -> the side not served last wins. `last_served` resets to write (first tie goes to read).
- WR_BURST: first cycle `cmd_en`=1, `cmd`=1, `addr`=latched; `wr_data`=`wr_data_in` combinationally, `wr_data_rd`=1 for BURST_WORDS consecutive cycles starting with the `cmd_en` cycle. Last word cycle: `wr_done`=1, go WR_RECOVER.
- WR_RECOVER: WR_RECOVERY cycles, then IDLE.
- RD_CMD: one cycle `cmd_en`=1, `cmd`=0, go RD_WAIT, start timeout counter.
- RD_WAIT/RD_DATA: each `rd_data_valid` beat registered to `rd_data_out`/`rd_data_out_valid` next cycle; beat counter counts to BURST_WORDS; `rd_done` asserted in same cycle as the last forwarded beat; then IDLE.
- Timeout: no first beat within RD_TIMEOUT cycles of `cmd_en` -> `error`=1 (sticky until reset), `rd_done` pulse, IDLE. Gaps between beats are not timed.
- `rd_data_valid` outside RD_WAIT/RD_DATA ignored; beats beyond BURST_WORDS ignored.
- `wr_req`/`rd_req` dropped mid-burst: burst still completes; done pulse still issued.

## Timing
- Reset values: `cmd_en`=0, `cmd`=0, `addr`=0, `wr_data_rd`=0, `wr_done`=0, `rd_data_out`=0, `rd_data_out_valid`=0, `rd_done`=0, `error`=0, state WAIT_INIT.
- Request to `cmd_en`: 1 cycle (request sampled in IDLE, strobe next cycle).
- Write burst occupies BURST_WORDS + WR_RECOVERY cycles after `cmd_en` cycle inclusive of burst.
- Read data latency through block: 1 cycle.
- Reset mid-burst: all outputs return to reset values immediately; no done pulse; state WAIT_INIT.
- `addr` and `cmd` hold last command value outside `cmd_en` cycles.

## Configuration
- `SDRAM_ARB_READ_PRIORITY_EN` defined: read always wins when both request (display never starves); `last_served` unused.
- Undefined: round-robin as above.

## Test plan
- Single write: `wr_req`, `wr_addr`=0x12C00, BURST_WORDS=8 -> one `cmd_en` with `cmd`=1, `addr`=0x12C00, 8 `wr_data_rd` cycles, `wr_done` on 8th, next `cmd_en` no earlier than 4 cycles later.
- Single read: `rd_addr`=0x40, model returns 8 beats after 4 cycles -> 8 `rd_data_out_valid` beats matching model data 1 cycle delayed, `rd_done` with 8th.
- Simultaneous `wr_req`+`rd_req` held for 4 bursts -> grants alternate R,W,R,W; with `SDRAM_ARB_READ_PRIORITY_EN` -> R,R,R,R.
- Read with no `rd_data_valid` -> `error`=1 exactly 64 cycles after `cmd_en`, `rd_done` pulse, subsequent write still served.
- `init_done`=0 with requests pending -> no `cmd_en`; first `cmd_en` 1 cycle after leaving WAIT_INIT/IDLE sample.
- `rst_n` asserted during 4th read beat -> outputs at reset values, no `rd_done`; after release and `init_done`, fresh read completes normally.
